sccb_encoder: RTL
=================

SCCB_ENCODER -- requirements
Module: sccb_encoder

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250, meaning system clocks per SCL quarter-period (legal range 2..65535).
REQ-002 SHALL have parameter DEVICE_ID, default 8'h42, meaning the 8-bit SCCB write ID sent in phase 1.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start_i, input, 1, write request, sampled every clk.
REQ-006 SHALL have port data_i, input, 16, {register address[15:8], register data[7:0]}.
REQ-007 SHALL have port busy_o, output, 1, high while a frame is in progress.
REQ-008 SHALL have port done_o, output, 1, one-clk pulse at frame completion.
REQ-009 SHALL have port sccb_scl, output, 1, SCCB clock (SIO_C), push-pull.
REQ-010 SHALL have port sccb_sda, output, 1, SCCB data (SIO_D), push-pull.

Function
REQ-011 SHALL advance frame timing only on a quarter tick, asserted for one clk every CLK_DIV clks while busy; the prescaler SHALL be held at 0 in IDLE.
REQ-012 SHALL implement states IDLE, START, BITS, STOP, DONE.
REQ-013 IDLE: scl=1, sda=1, busy_o=0; start_i=1 latches data_i and moves to START on the next clk, busy_o=1 from that edge.
REQ-014 START, 2 quarters: Q0 scl=1 sda=1; Q1 scl=1 sda=0 (start condition).
REQ-015 BITS SHALL send 27 bits MSB-first: DEVICE_ID[7:0], 1, addr[7:0], 1, data[7:0], 1; each ninth "don't-care" bit SHALL be driven 1.
REQ-016 Each bit SHALL occupy 4 quarters: Q0 scl=0 with sda updated, Q1 scl=0, Q2 scl=1, Q3 scl=1; sda SHALL only change while scl=0.
REQ-017 A 5-bit bit counter SHALL count 0..26; on Q3 of bit 26 the FSM SHALL go to STOP.
REQ-018 STOP, 3 quarters: Q0 scl=0 sda=0; Q1 scl=1 sda=0; Q2 scl=1 sda=1 (stop condition).
REQ-019 DONE SHALL last one clk: done_o=1, busy_o=0 from the following edge, return to IDLE.
REQ-020 A frame SHALL total 113 quarters and SHALL produce exactly 28 SCL rising edges: 27 data bits plus the stop edge.
REQ-021 start_i while busy_o=1 SHALL be ignored; data_i changes during a frame SHALL not affect it.
REQ-022 start_i held high continuously SHALL launch a new frame from IDLE the clk after DONE.
REQ-023 scl and sda SHALL be registered outputs with no combinational path from any input.

Reset
REQ-024 On rst_n=0, SHALL asynchronously set state=IDLE, prescaler=0, bit counter=0, shift register=0, scl=1, sda=1, busy_o=0, done_o=0.
REQ-025 Reset mid-frame SHALL abandon the frame with no stop condition and no done_o pulse; lines SHALL return high immediately.
REQ-026 After rst_n deasserts, the first start_i SHALL be accepted on the first rising clk edge.

Structure
REQ-027 Package sccb_pkg SHALL hold the state enum typedef, SCCB_FRAME_BITS=27, SCCB_DEFAULT_ID=8'h42 and the quarter counts for START (2) and STOP (3).
REQ-028 Prescaler SHALL be the sub-module sccb_tick_gen (inputs clk, rst_n, en; output tick), reusable by a later read-capable master.
REQ-029 Frame bits SHALL be held in a 27-bit shift register loaded at start accept.

Verification
REQ-030 CLK_DIV=2, data_i=16'h1280, one start_i pulse -> sccb_decoder monitor data_o=16'h1280; done_o once, 226 clks after acceptance (+/-1).
REQ-031 Back-to-back writes 16'h3A04 then 16'h40D0, start_i held high -> monitor shows both values in order; busy_o low for exactly one clk between frames.
REQ-032 start_i pulsed mid-frame with data_i=16'hFFFF -> ignored; first frame value unchanged; no second done_o.
REQ-033 rst_n asserted during bit 10 -> scl=sda=1 within the same clk (asynchronous); no done_o; next start_i produces a clean frame.
REQ-034 Protocol assertions on every frame: sda stable while scl=1 except the start and stop edges; exactly 28 scl rising edges per frame.
REQ-035 Idle check, no start_i for 1000 clks -> scl=1, sda=1, busy_o=0 throughout.

Source files
------------

// File: rtl/sccb_pkg.sv
// -----------------------------------------------------------------------------
// sccb_pkg
// Shared definitions for the SCCB (OmniVision serial camera control bus)
// master blocks: FSM state encoding, frame geometry and quarter counts for
// each protocol phase, plus a helper that assembles a 3-phase write frame.
// -----------------------------------------------------------------------------
package sccb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BITS,
        ST_STOP,
        ST_DONE
    } sccb_state_t;

    localparam int          SCCB_FRAME_BITS     = 27;
    localparam logic [7:0]  SCCB_DEFAULT_ID     = 8'h42;
    localparam int          SCCB_START_QUARTERS = 2;
    localparam int          SCCB_STOP_QUARTERS  = 3;
    localparam int          SCCB_BIT_QUARTERS   = 4;

    // Three 9-bit phases: ID, register address, register data. The ninth
    // bit of each phase is the slave's don't-care slot, which a write-only
    // master drives high.
    function automatic logic [SCCB_FRAME_BITS-1:0] sccb_frame(
        input logic [7:0]  id,
        input logic [15:0] data
    );
        return {id, 1'b1, data[15:8], 1'b1, data[7:0], 1'b1};
    endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// -----------------------------------------------------------------------------
// sccb_tick_gen
// Prescaler producing a one-clk tick every CLK_DIV clks while enabled. The
// count is forced back to zero whenever en is low, so the first tick after
// enabling always arrives exactly CLK_DIV clks later.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   en     count enable
//   tick   one-clk pulse on the last count of each CLK_DIV period
// -----------------------------------------------------------------------------
module sccb_tick_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/sccb_encoder.sv
// -----------------------------------------------------------------------------
// sccb_encoder
// Write-only SCCB master. A start request latches a 16-bit {address, data}
// word and emits a 3-phase write frame (ID, address, data, each followed by
// a high don't-care bit) framed by start and stop conditions. All bus timing
// is counted in SCL quarter-periods of CLK_DIV system clocks.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start_i   write request, ignored while busy_o is high
//   data_i    {register address[15:8], register data[7:0]}
//   busy_o    high from request acceptance through the DONE clk
//   done_o    one-clk pulse when the frame completes
//   sccb_scl  SIO_C, registered push-pull output
//   sccb_sda  SIO_D, registered push-pull output
// -----------------------------------------------------------------------------
module sccb_encoder
    import sccb_pkg::*;
#(
    parameter int         CLK_DIV   = 250,
    parameter logic [7:0] DEVICE_ID = SCCB_DEFAULT_ID
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [15:0] data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        sccb_scl,
    output logic        sccb_sda
);

    localparam logic [1:0] LAST_START_Q = 2'(SCCB_START_QUARTERS - 1);
    localparam logic [1:0] LAST_BIT_Q   = 2'(SCCB_BIT_QUARTERS - 1);
    localparam logic [1:0] LAST_STOP_Q  = 2'(SCCB_STOP_QUARTERS - 1);
    localparam logic [4:0] LAST_BIT     = 5'(SCCB_FRAME_BITS - 1);

    sccb_state_t                state, state_n;
    logic [1:0]                 quarter, quarter_n;
    logic [4:0]                 bit_cnt, bit_cnt_n;
    logic [SCCB_FRAME_BITS-1:0] shreg, shreg_n;
    logic                       scl_n, sda_n, busy_n, done_n;
    logic                       tick, tick_en;

    // The prescaler only runs during the timed phases; IDLE and DONE hold it
    // at zero so each frame's quarters line up with its acceptance edge.
    assign tick_en = (state == ST_START) || (state == ST_BITS) ||
                     (state == ST_STOP);

    sccb_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .tick  (tick)
    );

    // Next-state logic: frame position advances only on quarter ticks.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n   = state;
        quarter_n = quarter;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_n   = ST_START;
                    quarter_n = '0;
                    bit_cnt_n = '0;
                    shreg_n   = sccb_frame(DEVICE_ID, data_i);
                end
            end
            ST_START: begin
                if (tick) begin
                    if (quarter == LAST_START_Q) begin
                        state_n   = ST_BITS;
                        quarter_n = '0;
                    end else begin
                        quarter_n = quarter + 2'd1;
                    end
                end
            end
            ST_BITS: begin
                if (tick) begin
                    if (quarter == LAST_BIT_Q) begin
                        quarter_n = '0;
                        if (bit_cnt == LAST_BIT) begin
                            state_n = ST_STOP;
                        end else begin
                            bit_cnt_n = bit_cnt + 5'd1;
                            shreg_n   = {shreg[SCCB_FRAME_BITS-2:0], 1'b0};
                        end
                    end else begin
                        quarter_n = quarter + 2'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (quarter == LAST_STOP_Q) begin
                        state_n   = ST_DONE;
                        quarter_n = '0;
                    end else begin
                        quarter_n = quarter + 2'd1;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Line levels are decoded from the next position and registered, so the
    // pins change on the same edge as the state and never glitch.
    always_comb begin
        scl_n = 1'b1;
        sda_n = 1'b1;
        case (state_n)
            ST_START: sda_n = (quarter_n == 2'd0);
            ST_BITS: begin
                scl_n = quarter_n[1];
                sda_n = shreg_n[SCCB_FRAME_BITS-1];
            end
            ST_STOP: begin
                scl_n = (quarter_n != 2'd0);
                sda_n = (quarter_n == LAST_STOP_Q);
            end
            default: ;
        endcase
        busy_n = (state_n != ST_IDLE);
        done_n = (state_n == ST_DONE);
    end

    // NOTE: the frame shift register is ordinary control state, so it takes
    // the async reset along with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            quarter  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            sccb_scl <= 1'b1;
            sccb_sda <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state    <= state_n;
            quarter  <= quarter_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            sccb_scl <= scl_n;
            sccb_sda <= sda_n;
            busy_o   <= busy_n;
            done_o   <= done_n;
        end
    end

endmodule
